// File: rtl/rr_encoder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_encoder_arbiter_if
// Description : Request/grant bundle between eight requesters and the
//               round-robin encoder arbiter.
//               master : requester side (drives en/req/done)
//               slave  : arbiter side   (drives gnt/gnt_idx/gnt_valid/timeout)
//   en        1  arbiter enable
//   req       8  request vector, bit i = requester i
//   done      1  owner release pulse
//   gnt       8  registered one-hot grant
//   gnt_idx   3  binary index of the granted requester
//   gnt_valid 1  grant present
//   timeout   1  one-cycle pulse on a forced release
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_encoder_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_encoder_arbiter
// Description : Round-robin arbiter in front of an 8-to-3 encoder datapath.
//               Picks the first requester at or after a rotating pointer,
//               registers a one-hot grant plus its index and holds it until
//               the owner releases it (done, request withdrawal, en low, or
//               hold limit). The pointer moves to owner+1 on every release.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               arb    - rr_encoder_arbiter_if.slave request/grant bundle
// Parameters  : MAX_HOLD - hold limit in cycles (1..255), timeout build only
// Options     : ARB_TIMEOUT_EN - when defined, adds the hold counter and the
//               forced-release timeout pulse; otherwise timeout is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  rr_encoder_arbiter_if.slave   arb
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_encoder_arbiter: MAX_HOLD must be within 1..255");
  end

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;

  logic       w_pick_hit;
  logic [2:0] w_pick_idx;
  logic       w_other_rel;
  logic       w_release;

  // Rotated priority search. Candidates are visited farthest-first so the
  // last hit written is the one nearest to the pointer.
  always_comb begin : p_pick
    logic [2:0] l_cand;
    w_pick_hit = 1'b0;
    w_pick_idx = 3'd0;
    l_cand     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      l_cand = r_ptr + 3'(i);
      if (arb.req[l_cand]) begin
        w_pick_hit = 1'b1;
        w_pick_idx = l_cand;
      end
    end
  end

  assign w_other_rel = arb.done | ~arb.req[r_gnt_idx] | ~arb.en;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic       r_timeout;
  logic       w_hold_hit;

  assign w_hold_hit = (r_hold_cnt == c_HOLD_LAST);
  assign w_release  = w_other_rel | w_hold_hit;
`else
  assign w_release  = w_other_rel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd0;
      r_gnt       <= 8'd0;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
      // Counts cycles already spent in BUSY; zero on the first BUSY cycle.
      if (r_state == ST_BUSY) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end else begin
        r_hold_cnt <= 8'd0;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (arb.en && w_pick_hit) begin
            r_state     <= ST_BUSY;
            r_gnt       <= 8'd1 << w_pick_idx;
            r_gnt_idx   <= w_pick_idx;
            r_gnt_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
            // Only a pure hold-limit release counts as a timeout.
            r_timeout   <= w_hold_hit & ~w_other_rel;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb.gnt       = r_gnt;
  assign arb.gnt_idx   = r_gnt_idx;
  assign arb.gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout   = r_timeout;
`else
  assign arb.timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rr_encoder_arbiter.md
# rr_encoder_arbiter

Round-robin arbiter that shares one 8-input priority-encoded resource between eight requesters. It sits in front of the 8-to-3 encoder datapath: it turns a raw request vector into a single registered one-hot grant plus its 3-bit index, then holds that grant until the owner releases it. A rotating priority pointer guarantees that every persistently asserted requester is served within 8 grant cycles.

## Interface
Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held; range 1..255; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  arbiter enable; when low, no new grants are issued.
- req  input  8  request vector; bit i = requester i.
- done  input  1  owner release pulse, sampled only in BUSY.
- gnt  output  8  registered one-hot grant; all zero when nothing is granted.
- gnt_idx  output  3  binary index of the set gnt bit; 0 when gnt is zero.
- gnt_valid  output  1  high while gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released; tied 0 without ARB_TIMEOUT_EN.

## Operation
- Two states: IDLE and BUSY. Internal 3-bit priority pointer ptr.
- Reset: state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold counter=0.
- IDLE, with en=1 and req!=0: select the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8). Register gnt/gnt_idx for that bit. Go to BUSY.
- IDLE, with en=0 or req=0: stay in IDLE with outputs zero.
- BUSY, release conditions, any of:
  - done=1
  - req[gnt_idx]=0 (requester withdrew)
  - en=0
  - hold limit reached (macro builds only)
- On release: next edge clears gnt/gnt_idx/gnt_valid, sets ptr=gnt_idx+1 (3-bit wrap, so 7 -> 0), and returns to IDLE.
- BUSY with no release condition: hold grant unchanged. Changes on other req bits are ignored.
- done in IDLE: ignored.
- gnt_idx is always the binary encoding of gnt. gnt is never multi-hot.

## Timing
- Grant latency: req sampled in IDLE at edge k; gnt valid after edge k, i.e. one cycle.
- Release latency: release condition at edge k; gnt zero after edge k.
- The earliest next grant is after edge k+1, so there is always at least one idle cycle between consecutive grants.
- Back-to-back throughput: one grant per 2 cycles minimum when done is pulsed in the first BUSY cycle.
- Fairness: with all req bits held high and done pulsed each grant, the grant order is 0,1,2,…,7,0.
- Pointer wrap: a grant to 7 followed by release sets ptr=0.
- rst_n low at any time, including mid-grant: all outputs clear immediately (asynchronously), ptr=0, state=IDLE. First grant can occur one cycle after the first clk edge with rst_n high.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on grant entry and increments each BUSY cycle.
  - When the counter equals MAX_HOLD-1 with no other release condition, the grant is released on that edge with the normal ptr advance, and timeout pulses high for exactly one cycle, aligned with gnt going zero.
  - The grant is therefore held at most MAX_HOLD cycles.
- ARB_TIMEOUT_EN undefined: no counter logic; a grant is held indefinitely until done, request withdrawal or en=0; timeout is constant 0.

## Test plan
- Reset then en=1, req=8'b0000_0100 -> one cycle later gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; pulse done -> next cycle gnt=0; ptr=3.
- en=1, req=8'hFF held, done pulsed every BUSY cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0 with one idle cycle between grants.
- ptr=3 (after grant to 2), req=8'b0000_0011 -> wrap search grants idx 0, then idx 1 on the next arbitration.
- Grant idx 5 held, rst_n pulsed low mid-grant -> gnt=0, gnt_idx=0, gnt_valid=0 immediately without a clock edge; after release the next grant with req=8'hFF is idx 0.
- en=0 with req=8'h81 -> no grant; while BUSY on idx 0, drop en -> release next edge, ptr=1.
- ARB_TIMEOUT_EN with MAX_HOLD=4, req[6] held, done=0 -> gnt_valid high for exactly 4 cycles, then timeout=1 for one cycle with gnt=0; regrant of idx 6 follows one cycle later if it is the only requester.
